updown_counter_mod: RTL and testbench
=====================================

Name: updown_counter_mod

Overview:
- Parametrised up/down counter. Successor to the fixed 8-bit free-running up/down counter.
- Adds:
  - configurable width and modulus
  - wrap or saturate mode
  - synchronous parallel load
  - terminal-count and boundary flags
- Used as a generic event/timer counter in block-level testbenches and small datapaths.

Parameters:
- WIDTH, 8: counter width in bits; legal range 2..32.
- MOD_MAX, 2**WIDTH-1: highest count value; count range is 0..MOD_MAX; must be in 1..2**WIDTH-1.
- SATURATE, 0: 0 = wrap at boundaries; 1 = hold at boundaries.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable.
- up_down  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- out  output  WIDTH  current count (registered).
- at_max  output  1  out == MOD_MAX (combinational from out).
- at_min  output  1  out == 0 (combinational from out).
- tc  output  1  terminal-count strobe (combinational): enable && !load && !reset && ((up_down && at_max) || (!up_down && at_min)).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. No asynchronous paths.
- Priority per rising edge: reset > load > enable > hold.
- Reset:
  - out <= 0, so at_min=1, at_max=0 (at_max=1 only if MOD_MAX==0, which is illegal), tc=0.
  - Reset mid-count takes effect on that edge regardless of load/enable.
- Load:
  - out <= load_val when load_val <= MOD_MAX, else out <= MOD_MAX (clamp).
  - Load ignores enable and up_down.
- Count (enable=1, load=0):
  - Up, out < MOD_MAX: out <= out+1.
  - Up, out == MOD_MAX: SATURATE=0 gives out <= 0; SATURATE=1 holds MOD_MAX.
  - Down, out > 0: out <= out-1.
  - Down, out == 0: SATURATE=0 gives out <= MOD_MAX; SATURATE=1 holds 0.
- Hold: enable=0 and load=0 leaves out unchanged; tc=0.
- Arithmetic:
  - Next-value computed in WIDTH+1 bits internally.
  - No intermediate value outside 0..MOD_MAX is ever registered, including non-power-of-2 MOD_MAX.
- tc:
  - Asserted in the same cycle as the boundary-crossing edge.
  - Asserts in both modes; in saturate mode it flags a blocked step.
- Latency:
  - Load/count visible on out one cycle after the sampling edge.
  - Flags follow out combinationally.
- Elaboration: illegal parameter combinations trigger an elaboration-time $error.

Optional Feature:
- Macro: UPDOWN_COUNTER_OVF_STICKY_EN.
- When defined, adds two ports:
  - input ovf_clr (1 bit)
  - output ovf_sticky (1 bit, registered)
- ovf_sticky behaviour:
  - Set on any edge where tc=1.
  - Cleared by reset or ovf_clr.
  - Set wins over clear on the same edge.
  - Reset value 0.
- When undefined: neither port exists; no extra flops.

Decomposition:
- Package counter_pkg:
  - typedef enum logic {DIR_DOWN=1'b0, DIR_UP=1'b1} dir_e
  - localparam MODE_WRAP=0, MODE_SAT=1
  - function clamp_load(val, max)
- Sub-module counter_next_val (purely combinational):
  - Inputs: out, up_down, SATURATE, MOD_MAX.
  - Outputs: next count and boundary hit.
  - Top level instantiates it once and owns the registers and priority logic.

Test Plan:
- Reset: WIDTH=8, count up to 0x37, assert reset one cycle with enable=1 and load=1 -> out=0x00, at_min=1 next cycle.
- Wrap, non-power-of-2 modulus: MOD_MAX=9, SATURATE=0, enable=1, up_down=1 from 0 for 12 cycles -> sequence 0..9,0,1,2; tc=1 only while out=9. Down from 0 -> 9, tc=1.
- Saturate: MOD_MAX=9, SATURATE=1, up 15 cycles -> out holds 9, tc=1 each cycle at 9. Down from 0 -> holds 0, tc=1.
- Load priority and clamp:
  - load=1, enable=1, load_val=5 -> out=5.
  - MOD_MAX=9, load_val=200 -> out=9, at_max=1.
- Enable gating and edge-only update: toggle enable=0 for 3 cycles mid-count at 0x10 with clk glitch-free and inputs changing between edges -> out stays 0x10; updates only on posedge.
- (UPDOWN_COUNTER_OVF_STICKY_EN) Wrap 255->0 -> ovf_sticky=1 and stays 1. Pulse ovf_clr -> 0. ovf_clr coincident with tc -> stays 1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types, mode constants and load clamping helper for the up/down counter.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Operands are carried at 32 bits, the widest legal counter.
    function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational successor of the current count: wraps or saturates at 0 and MOD_MAX.
module counter_next_val
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter longint unsigned  MOD_MAX  = (64'd1 << WIDTH) - 64'd1,
    parameter int               SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] out,
    input  logic             up_down,
    output logic [WIDTH-1:0] next_cnt,
    output logic             hit
);

    localparam logic [WIDTH:0]   MAX_EXT = MOD_MAX[WIDTH:0];
    localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_VAL = MOD_MAX[WIDTH-1:0];

    logic [WIDTH:0] cur_ext;
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;
    dir_e           dir;

    assign cur_ext = {1'b0, out};
    assign inc_ext = cur_ext + ONE_EXT;
    assign dec_ext = cur_ext - ONE_EXT;
    assign dir     = dir_e'(up_down);

    // The extra bit catches both overshoot past MOD_MAX and borrow below zero.
    always_comb begin
        next_cnt = out;
        hit      = 1'b0;
        if (dir == DIR_UP) begin
            if (inc_ext > MAX_EXT) begin
                hit      = 1'b1;
                next_cnt = (SATURATE == MODE_SAT) ? MAX_VAL : '0;
            end else begin
                next_cnt = inc_ext[WIDTH-1:0];
            end
        end else begin
            if (dec_ext[WIDTH]) begin
                hit      = 1'b1;
                next_cnt = (SATURATE == MODE_SAT) ? '0 : MAX_VAL;
            end else begin
                next_cnt = dec_ext[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with wrap/saturate, clamped load and boundary flags.
// Optional sticky overflow flag with ovf_clr when UPDOWN_COUNTER_OVF_STICKY_EN is defined.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter longint unsigned  MOD_MAX  = (64'd1 << WIDTH) - 64'd1,
    parameter int               SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
    input  logic             ovf_clr,
    output logic             ovf_sticky,
`endif
    output logic [WIDTH-1:0] out,
    output logic             at_max,
    output logic             at_min,
    output logic             tc
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter_mod: WIDTH %0d outside 2..32", WIDTH);
    end
    if (MOD_MAX < 1 || MOD_MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_mod
        $error("updown_counter_mod: MOD_MAX %0d outside 1..2**WIDTH-1", MOD_MAX);
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_sat
        $error("updown_counter_mod: SATURATE must be 0 or 1");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = MOD_MAX[WIDTH-1:0];

    logic [WIDTH-1:0] next_cnt;
    logic [WIDTH-1:0] load_clamped;
    logic             hit;

    counter_next_val #(
        .WIDTH   (WIDTH),
        .MOD_MAX (MOD_MAX),
        .SATURATE(SATURATE)
    ) u_next (
        .out     (out),
        .up_down (up_down),
        .next_cnt(next_cnt),
        .hit     (hit)
    );

    assign load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MOD_MAX)));

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (load) begin
            out <= load_clamped;
        end else if (enable) begin
            out <= next_cnt;
        end
    end

    assign at_max = (out == MAX_VAL);
    assign at_min = (out == '0);
    // hit already means "stepping off the boundary in the chosen direction".
    assign tc     = enable && !load && !reset && hit;

`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (tc) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: 8-bit full-range wrap, mod-10 wrap and mod-10 saturate.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [7:0] load_val;
    logic       ovf_clr;

    logic [7:0] out8, out9w, out9s;
    logic       max8, max9w, max9s;
    logic       min8, min9w, min9s;
    logic       tc8, tc9w, tc9s;
    logic       ovf8, ovf9w, ovf9s;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_val(load_val),
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        .ovf_clr(ovf_clr), .ovf_sticky(ovf8),
`endif
        .out(out8), .at_max(max8), .at_min(min8), .tc(tc8)
    );

    updown_counter_mod #(.WIDTH(8), .MOD_MAX(9), .SATURATE(0)) u_dut9w (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_val(load_val),
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        .ovf_clr(ovf_clr), .ovf_sticky(ovf9w),
`endif
        .out(out9w), .at_max(max9w), .at_min(min9w), .tc(tc9w)
    );

    updown_counter_mod #(.WIDTH(8), .MOD_MAX(9), .SATURATE(1)) u_dut9s (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_val(load_val),
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        .ovf_clr(ovf_clr), .ovf_sticky(ovf9s),
`endif
        .out(out9s), .at_max(max9s), .at_min(min9s), .tc(tc9s)
    );

`ifndef UPDOWN_COUNTER_OVF_STICKY_EN
    assign ovf8  = 1'b0;
    assign ovf9w = 1'b0;
    assign ovf9s = 1'b0;
`endif

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic en, input logic ud,
                         input logic ld, input logic [7:0] lv);
        reset    = rst;
        enable   = en;
        up_down  = ud;
        load     = ld;
        load_val = lv;
        #1;
    endtask

    // One active edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ovf_clr = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        tick();

        // Reset state; tc must stay low even at a boundary while reset is high.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_out8", 32'(out8), 32'h0);
        check("rst_min8", 32'(min8), 32'h1);
        check("rst_max8", 32'(max8), 32'h0);
        check("rst_tc9w", 32'(tc9w), 32'h0);
        check("rst_ovf8", 32'(ovf8), 32'h0);

        // Count up to 0x37, then reset with enable and load both high.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8'h37; i++) tick();
        check("up_to_37", 32'(out8), 32'h37);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
        tick();
        check("rst_mid_out", 32'(out8), 32'h0);
        check("rst_mid_min", 32'(min8), 32'h1);

        // Mod-10 up run: wrap gives 0..9,0,.. ; saturate holds at 9.
        do_reset();
        for (int i = 0; i <= 15; i++) exp_q.push_back(32'(i % 10));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 15; i++) begin
            logic [31:0] e;
            logic [31:0] es;
            e  = exp_q.pop_front();
            es = (i > 9) ? 32'd9 : 32'(i);
            check($sformatf("wrap_out[%0d]", i), 32'(out9w), e);
            check($sformatf("wrap_tc[%0d]", i), 32'(tc9w), 32'(e == 9));
            check($sformatf("sat_out[%0d]", i), 32'(out9s), es);
            check($sformatf("sat_tc[%0d]", i), 32'(tc9s), 32'(es == 9));
            tick();
        end
        check("wrap_out_end", 32'(out9w), exp_q.pop_front());
        check("sat_out_end", 32'(out9s), 32'd9);
        check("sat_max_end", 32'(max9s), 32'h1);

        // Down from 0: wrap goes to MOD_MAX, saturate holds 0; both flag tc.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("dn_wrap_tc", 32'(tc9w), 32'h1);
        check("dn_sat_tc", 32'(tc9s), 32'h1);
        tick();
        check("dn_wrap_out", 32'(out9w), 32'd9);
        check("dn_wrap_max", 32'(max9w), 32'h1);
        check("dn_sat_out", 32'(out9s), 32'd0);
        check("dn_sat_min", 32'(min9s), 32'h1);
        tick();
        check("dn_wrap_out2", 32'(out9w), 32'd8);

        // Load wins over enable and is clamped to MOD_MAX.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
        check("ld_tc_w", 32'(tc9w), 32'h0);
        tick();
        check("ld5_out8", 32'(out8), 32'd5);
        check("ld5_out9w", 32'(out9w), 32'd5);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd200);
        check("ld_tc_s_at_max", 32'(tc9s), 32'h0);
        tick();
        check("ld200_out8", 32'(out8), 32'd200);
        check("ld200_out9w", 32'(out9w), 32'd9);
        check("ld200_max9w", 32'(max9w), 32'h1);
        check("ld200_out9s", 32'(out9s), 32'd9);

        // Enable gating: inputs wiggle mid-cycle, output moves only on an enabled edge.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h10);
        tick();
        check("gate_ld", 32'(out8), 32'h10);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'(i), 1'b0, 8'(i * 37));
            #2;
            drive(1'b0, 1'b0, 1'(i + 1), 1'b0, 8'hFF);
            check($sformatf("gate_tc[%0d]", i), 32'(tc8), 32'h0);
            tick();
            check($sformatf("gate_out[%0d]", i), 32'(out8), 32'h10);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        check("gate_pre_edge", 32'(out8), 32'h10);
        tick();
        check("gate_resume", 32'(out8), 32'h11);

`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        // Sticky overflow: set on 255->0, held, cleared by ovf_clr, set beats clear.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        check("ovf_tc", 32'(tc8), 32'h1);
        check("ovf_pre", 32'(ovf8), 32'h0);
        tick();
        check("ovf_wrap_out", 32'(out8), 32'h0);
        check("ovf_set", 32'(ovf8), 32'h1);
        tick();
        tick();
        check("ovf_hold", 32'(ovf8), 32'h1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf8), 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(ovf8), 32'h1);
        do_reset();
        check("ovf_rst", 32'(ovf8), 32'h0);
`endif

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
